// File: rtl/hazard_unit.sv
// Hazard and forwarding controller for the RV32I 5-stage pipeline.
// Tracks E/M/W register addresses and produces forward selects, load-use stalls and flushes.
module hazard_unit #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] rs1_D,
    input  logic [REG_ADDR_W-1:0] rs2_D,
    input  logic [REG_ADDR_W-1:0] rd_D,
    input  logic                  usesRs1_D,
    input  logic                  usesRs2_D,
    input  logic                  regWrite_D,
    input  logic                  isLoad_D,
    input  logic                  pcSrc_E,
    output logic [1:0]            forwardA_E,
    output logic [1:0]            forwardB_E,
    output logic                  stall_F,
    output logic                  stall_D,
    output logic                  flush_D,
    output logic                  flush_E
);

    localparam logic [REG_ADDR_W-1:0] REG_X0  = {REG_ADDR_W{1'b0}};
    localparam logic [1:0]            FWD_RF  = 2'b00;
    localparam logic [1:0]            FWD_WB  = 2'b01;
    localparam logic [1:0]            FWD_MEM = 2'b10;

    logic [REG_ADDR_W-1:0] rs1_e_q, rs1_e_d;
    logic [REG_ADDR_W-1:0] rs2_e_q, rs2_e_d;
    logic [REG_ADDR_W-1:0] rd_e_q,  rd_e_d;
    logic                  reg_write_e_q, reg_write_e_d;
    logic                  is_load_e_q,   is_load_e_d;
    logic [REG_ADDR_W-1:0] rd_m_q,  rd_m_d;
    logic                  reg_write_m_q, reg_write_m_d;
    logic [REG_ADDR_W-1:0] rd_w_q,  rd_w_d;
    logic                  reg_write_w_q, reg_write_w_d;

    logic                  lw_stall_s;
    logic [1:0]            fwd_a_s;
    logic [1:0]            fwd_b_s;

    // The youngest producer (M) wins over W; x0 never forwards.
    function automatic logic [1:0] fwd_select(
        input logic [REG_ADDR_W-1:0] src,
        input logic                  wr_m,
        input logic [REG_ADDR_W-1:0] rd_m,
        input logic                  wr_w,
        input logic [REG_ADDR_W-1:0] rd_w
    );
        logic [1:0] sel;
        if (wr_m && (rd_m != REG_X0) && (rd_m == src)) begin
            sel = FWD_MEM;
        end else if (wr_w && (rd_w != REG_X0) && (rd_w == src)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

    // Forward selects, load-use detection and stall/flush outputs.
    always_comb begin
        fwd_a_s    = fwd_select(rs1_e_q, reg_write_m_q, rd_m_q, reg_write_w_q, rd_w_q);
        fwd_b_s    = fwd_select(rs2_e_q, reg_write_m_q, rd_m_q, reg_write_w_q, rd_w_q);
        lw_stall_s = is_load_e_q && (rd_e_q != REG_X0) &&
                     ((usesRs1_D && (rs1_D == rd_e_q)) ||
                      (usesRs2_D && (rs2_D == rd_e_q)));
        forwardA_E = fwd_a_s;
        forwardB_E = fwd_b_s;
        stall_F    = lw_stall_s & ~pcSrc_E;
        stall_D    = lw_stall_s & ~pcSrc_E;
        flush_D    = pcSrc_E;
        flush_E    = lw_stall_s | pcSrc_E;
    end

    // Next shadow state: M/W always advance; E takes D or a bubble on flush.
    always_comb begin
        rd_m_d        = rd_e_q;
        reg_write_m_d = reg_write_e_q;
        rd_w_d        = rd_m_q;
        reg_write_w_d = reg_write_m_q;
        rs1_e_d       = REG_X0;
        rs2_e_d       = REG_X0;
        rd_e_d        = REG_X0;
        reg_write_e_d = 1'b0;
        is_load_e_d   = 1'b0;
        if (flush_E) begin
            rs1_e_d       = REG_X0;
            rs2_e_d       = REG_X0;
            rd_e_d        = REG_X0;
            reg_write_e_d = 1'b0;
            is_load_e_d   = 1'b0;
        end else begin
            rs1_e_d       = usesRs1_D ? rs1_D : REG_X0;
            rs2_e_d       = usesRs2_D ? rs2_D : REG_X0;
            rd_e_d        = rd_D;
            reg_write_e_d = regWrite_D;
            is_load_e_d   = isLoad_D;
        end
    end

    // Shadow pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rs1_e_q       <= REG_X0;
            rs2_e_q       <= REG_X0;
            rd_e_q        <= REG_X0;
            reg_write_e_q <= 1'b0;
            is_load_e_q   <= 1'b0;
            rd_m_q        <= REG_X0;
            reg_write_m_q <= 1'b0;
            rd_w_q        <= REG_X0;
            reg_write_w_q <= 1'b0;
        end else begin
            rs1_e_q       <= rs1_e_d;
            rs2_e_q       <= rs2_e_d;
            rd_e_q        <= rd_e_d;
            reg_write_e_q <= reg_write_e_d;
            is_load_e_q   <= is_load_e_d;
            rd_m_q        <= rd_m_d;
            reg_write_m_q <= reg_write_m_d;
            rd_w_q        <= rd_w_d;
            reg_write_w_q <= reg_write_w_d;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit with hand-computed expectations.
module tb_hazard_unit;

    logic       clk;
    logic       reset;
    logic [4:0] rs1_D, rs2_D, rd_D;
    logic       usesRs1_D, usesRs2_D, regWrite_D, isLoad_D, pcSrc_E;
    logic [1:0] forwardA_E, forwardB_E;
    logic       stall_F, stall_D, flush_D, flush_E;

    int checks_r;
    int errors_r;

    hazard_unit #(.REG_ADDR_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .rs1_D      (rs1_D),
        .rs2_D      (rs2_D),
        .rd_D       (rd_D),
        .usesRs1_D  (usesRs1_D),
        .usesRs2_D  (usesRs2_D),
        .regWrite_D (regWrite_D),
        .isLoad_D   (isLoad_D),
        .pcSrc_E    (pcSrc_E),
        .forwardA_E (forwardA_E),
        .forwardB_E (forwardB_E),
        .stall_F    (stall_F),
        .stall_D    (stall_D),
        .flush_D    (flush_D),
        .flush_E    (flush_E)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks_r++;
        if (obs !== exp) begin
            errors_r++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_d(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic u1, input logic u2, input logic rw, input logic ld);
        rs1_D = rs1; rs2_D = rs2; rd_D = rd;
        usesRs1_D = u1; usesRs2_D = u2; regWrite_D = rw; isLoad_D = ld;
    endtask

    task automatic set_nop();
        set_d(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one Decode instruction for one cycle, then return to a nop.
    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic u1, input logic u2, input logic rw, input logic ld);
        set_d(rs1, rs2, rd, u1, u2, rw, ld);
        tick();
        set_nop();
    endtask

    task automatic check_ctrl(input string tag, input logic sf, input logic sd,
                              input logic fd, input logic fe);
        check_eq({tag, "_stall_F"}, {3'd0, stall_F}, {3'd0, sf});
        check_eq({tag, "_stall_D"}, {3'd0, stall_D}, {3'd0, sd});
        check_eq({tag, "_flush_D"}, {3'd0, flush_D}, {3'd0, fd});
        check_eq({tag, "_flush_E"}, {3'd0, flush_E}, {3'd0, fe});
    endtask

    initial begin
        checks_r = 0;
        errors_r = 0;
        reset    = 1'b1;
        pcSrc_E  = 1'b0;
        // Reset with random Decode inputs.
        for (int i = 0; i < 2; i++) begin
            set_d(5'($urandom_range(31)), 5'($urandom_range(31)), 5'($urandom_range(31)),
                  1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                  1'($urandom_range(1)));
            tick();
        end
        check_eq("rst_fwdA", {2'd0, forwardA_E}, 4'd0);
        check_eq("rst_fwdB", {2'd0, forwardB_E}, 4'd0);
        check_ctrl("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        set_nop();
        tick();
        tick();

        // EX->EX: add x5 then sub x10, x5, x1.
        issue(5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        issue(5'd5, 5'd1, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0);
        check_eq("exex_fwdA", {2'd0, forwardA_E}, 4'd2);
        check_eq("exex_fwdB", {2'd0, forwardB_E}, 4'd0);
        check_ctrl("exex", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();

        // M beats W: writers x6, x6, then reader rs2=x6 (rs1 field x6 but unused).
        issue(5'd0, 5'd0, 5'd6, 1'b0, 1'b0, 1'b1, 1'b0);
        issue(5'd0, 5'd0, 5'd6, 1'b0, 1'b0, 1'b1, 1'b0);
        issue(5'd6, 5'd6, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("prio_fwdB", {2'd0, forwardB_E}, 4'd2);
        check_eq("unused_rs1_fwdA", {2'd0, forwardA_E}, 4'd0);
        tick();
        tick();

        // W forwarding: writer x7, nop, reader rs2=x7.
        issue(5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        issue(5'd0, 5'd7, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("wb_fwdB", {2'd0, forwardB_E}, 4'd1);
        tick();
        tick();

        // x0 producer never forwards.
        issue(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        issue(5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        check_eq("x0_fwdA", {2'd0, forwardA_E}, 4'd0);
        check_eq("x0_fwdB", {2'd0, forwardB_E}, 4'd0);
        tick();
        tick();

        // Non-writer (store) with rd field x8 followed by a reader of x8.
        issue(5'd1, 5'd2, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
        issue(5'd8, 5'd0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0);
        check_eq("store_fwdA", {2'd0, forwardA_E}, 4'd0);
        tick();
        tick();

        // Load-use: lw x9 then add rs1=x9, held in Decode through the stall.
        issue(5'd1, 5'd0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1);
        set_d(5'd9, 5'd2, 5'd11, 1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        check_ctrl("lu_c0", 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        check_ctrl("lu_c1", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        set_nop();
        #1;
        check_eq("lu_fwdA", {2'd0, forwardA_E}, 4'd1);
        tick();
        tick();

        // Load followed by a reader that does not use rs1: no stall.
        issue(5'd1, 5'd0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1);
        set_d(5'd9, 5'd3, 5'd12, 1'b0, 1'b1, 1'b1, 1'b0);
        #1;
        check_ctrl("nouse", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        set_nop();
        tick();
        tick();

        // Branch flush: writer x4, then a writer x12 reading x4 is squashed.
        issue(5'd0, 5'd0, 5'd4, 1'b0, 1'b0, 1'b1, 1'b0);
        set_d(5'd4, 5'd0, 5'd12, 1'b1, 1'b0, 1'b1, 1'b0);
        pcSrc_E = 1'b1;
        #1;
        check_ctrl("br", 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        pcSrc_E = 1'b0;
        set_nop();
        #1;
        check_eq("br_bubble_fwdA", {2'd0, forwardA_E}, 4'd0);
        issue(5'd12, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("br_squash_fwdA", {2'd0, forwardA_E}, 4'd0);
        tick();
        tick();

        // Branch together with a load-use hazard: flush wins.
        issue(5'd1, 5'd0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1);
        set_d(5'd9, 5'd0, 5'd13, 1'b1, 1'b0, 1'b1, 1'b0);
        pcSrc_E = 1'b1;
        #1;
        check_ctrl("br_lu", 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        pcSrc_E = 1'b0;
        set_nop();
        tick();
        tick();

        // Reset during a stall clears the load from the shadow pipeline.
        issue(5'd1, 5'd0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1);
        set_d(5'd9, 5'd0, 5'd14, 1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        check_ctrl("rst_stall_pre", 1'b1, 1'b1, 1'b0, 1'b1);
        reset = 1'b1;
        tick();
        check_ctrl("rst_stall_post", 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("rst_stall_fwdA", {2'd0, forwardA_E}, 4'd0);
        reset = 1'b0;
        issue(5'd9, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("rst_stall_wb_fwdA", {2'd0, forwardA_E}, 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks_r, errors_r);
        $finish;
    end

endmodule
